// File: rtl/muldiv_if.sv
// Request/response bundle between the issue logic and the multiply/divide unit.
// The master issues start/funct3/operands; the slave returns busy/done/result.
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 cycles per op, one bit per cycle,
// shared 64-bit shift register for shift-add multiply and restoring divide.
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | iterating, counter 0..31
//   DONE  | result valid, done pulse
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2:0]     f3_q;
  logic [W-1:0]   opnd_q;
  logic [2*W-1:0] acc;
  logic           res_neg;
  logic [5:0]     cnt;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   result_q;

  // operand conditioning for the accepting edge
  logic         a_sgn, b_sgn, a_neg, b_neg, start_neg, start_div;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn     = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
    b_sgn     = a_sgn && (bus.funct3 != 3'b010);
    a_neg     = a_sgn & bus.op_a[W-1];
    b_neg     = b_sgn & bus.op_b[W-1];
    a_mag     = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    b_mag     = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
    start_div = bus.funct3[2];
    // remainder takes the dividend's sign; everything else the xor of both
    start_neg = (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // one iteration of either datapath
  logic [W:0]     mul_sum;
  logic [W:0]     div_sh, div_diff;
  logic           div_ge;
  logic [2*W-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_sh   = acc[2*W-1:W-1];
    div_ge   = div_sh >= {1'b0, opnd_q};
    div_diff = div_sh - {1'b0, opnd_q};
    if (f3_q[2])
      acc_next = {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), acc[W-2:0], div_ge};
    else
      acc_next = {mul_sum, acc[W-1:1]};
  end

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s, rem_s, final_res;

  // divide-by-zero needs an explicit override; the overflow case falls out naturally
  always_comb begin
    prod_s    = res_neg ? (~acc_next + 1'b1) : acc_next;
    quot_s    = res_neg ? (~acc_next[W-1:0] + 1'b1) : acc_next[W-1:0];
    rem_s     = res_neg ? (~acc_next[2*W-1:W] + 1'b1) : acc_next[2*W-1:W];
    final_res = '0;
    case (f3_q)
      3'b000:                final_res = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*W-1:W];
      3'b100, 3'b101:        final_res = (opnd_q == '0) ? '1 : quot_s;
      default:               final_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      f3_q     <= '0;
      opnd_q   <= '0;
      acc      <= '0;
      res_neg  <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            f3_q    <= bus.funct3;
            opnd_q  <= start_div ? b_mag : a_mag;
            acc     <= {{W{1'b0}}, (start_div ? a_mag : b_mag)};
            res_neg <= start_neg;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= CALC;
          end else begin
            state   <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            result_q <= final_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, control
// handling (ignored start, back-to-back, mid-op reset).
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  muldiv_if #(.DATA_WIDTH(32)) bus ();

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // drive at negedge, return #1 after the accepting edge
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // returns edges waited until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
  endtask

  int lat;
  int done_cnt;
  int busy_cnt;

  initial begin
    n_chk = 0;
    n_pass = 0;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'b111, 32'd5,        32'd0,        32'd5};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    #1;
    chk("rst_busy",   {31'b0, bus.busy}, 32'd0);
    chk("rst_done",   {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result,        32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // full vector table; busy counted over the op, must equal 32
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].f3, vecs[i].a, vecs[i].b);
      busy_cnt = 0;
      lat = 0;
      for (int c = 0; c < 40; c++) begin
        if (bus.busy) busy_cnt++;
        @(posedge clk);
        #1;
        lat++;
        if (bus.done) break;
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd32);
      chk($sformatf("vec%0d_busy", i), 32'(busy_cnt), 32'd32);
      chk($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
    chk("result_hold",    bus.result,        32'd0);

    // start during CALC must be ignored
    start_op(3'b000, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b011;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd100;
    @(negedge clk);
    bus.start  = 1'b0;
    lat = 10;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    chk("ignore_latency", 32'(lat), 32'd32);
    chk("ignore_result",  bus.result, 32'd15);

    // back-to-back: start held during the done cycle
    start_op(3'b101, 32'd100, 32'd7);
    wait_done(lat);
    chk("b2b_first",   bus.result, 32'd14);
    bus.start  = 1'b1;
    bus.funct3 = 3'b111;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    chk("b2b_busy",    {31'b0, bus.busy}, 32'd1);
    chk("b2b_done_lo", {31'b0, bus.done}, 32'd0);
    wait_done(lat);
    chk("b2b_latency", 32'(lat), 32'd32);
    chk("b2b_second",  bus.result, 32'd2);

    // reset mid-DIV: immediate clear, no done afterwards
    start_op(3'b100, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   {31'b0, bus.busy}, 32'd0);
    chk("abort_done",   {31'b0, bus.done}, 32'd0);
    chk("abort_result", bus.result,        32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    start_op(3'b100, 32'd1000, 32'd3);
    wait_done(lat);
    chk("after_rst_latency", 32'(lat), 32'd32);
    chk("after_rst_result",  bus.result, 32'd333);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
